// File: rtl/exec_wb_pkg.sv
// Shared definitions for the execute/write-back unit.
// Holds the 9-bit instruction field layout, opcode encodings, FSM state
// encodings and small decode helpers used by exec_wb_unit and alu_32bit.
package exec_wb_pkg;

    // Instruction layout: op[8:6], rd[5:4], rs1[3:2], rs2[1:0]
    localparam int INSTR_W = 9;
    localparam int OP_MSB  = 8;
    localparam int OP_LSB  = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 4;
    localparam int RS1_MSB = 3;
    localparam int RS1_LSB = 2;
    localparam int RS2_MSB = 1;
    localparam int RS2_LSB = 0;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_NOP = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_EXEC = 2'b10,
        ST_WB   = 2'b11
    } state_e;

    // NOP is the only opcode that retires without touching the register file.
    function automatic logic op_writes_reg(input op_e op);
        return (op != OP_NOP);
    endfunction

    // Only the arithmetic ops produce a meaningful carry/borrow.
    function automatic logic op_sets_carry(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_32bit.sv
// Combinational ALU for exec_wb_unit.
// Ports: a, b     - operands
//        op       - opcode (exec_wb_pkg::op_e)
//        result   - operation result (ADD/SUB wrap modulo 2^DATA_W)
//        carry    - ADD carry-out, or SUB unsigned borrow (a < b); 0 otherwise
module alu_32bit
    import exec_wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  op_e               op,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    localparam int SHAMT_W = $clog2(DATA_W);

    logic [DATA_W:0] sum_s;
    logic [DATA_W:0] diff_s;
    logic            slt_s;

    // Extra top bit gives carry-out for ADD and borrow for SUB.
    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} - {1'b0, b};
    assign slt_s  = ($signed(a) < $signed(b));

    // Opcode decode
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum_s[DATA_W-1:0];
                carry  = sum_s[DATA_W];
            end
            OP_SUB: begin
                result = diff_s[DATA_W-1:0];
                carry  = diff_s[DATA_W];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, slt_s};
            OP_SLL:  result = a << b[SHAMT_W-1:0];
            OP_NOP:  result = '0;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/exec_wb_unit.sv
// Multi-cycle execute/write-back unit: IDLE -> READ -> EXEC -> WB -> IDLE,
// one instruction in flight, one instruction per 4 cycles.
// Ports: clk, reset (sync, active-high)
//        instr/instr_valid/instr_ready - instruction handshake (ready only in IDLE)
//        ReadReg1/2, ReadData1/2       - register-file read port (data combinational)
//        WriteReg/WriteData/RegWrite   - register-file write port (WB cycle only)
//        done       - one-cycle pulse per retired instruction
//        zero_flag  - last non-NOP result was zero
//        carry_flag - carry/borrow of last ADD/SUB
//        retired    - wrapping count of retired instructions
module exec_wb_unit
    import exec_wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [ADDR_W-1:0]  ReadReg1,
    output logic [ADDR_W-1:0]  ReadReg2,
    input  logic [DATA_W-1:0]  ReadData1,
    input  logic [DATA_W-1:0]  ReadData2,
    output logic [ADDR_W-1:0]  WriteReg,
    output logic [DATA_W-1:0]  WriteData,
    output logic               RegWrite,
    output logic               done,
    output logic               zero_flag,
    output logic               carry_flag,
    output logic [7:0]         retired
);

    state_e              state_r, state_s;
    logic                accept_s;
    op_e                 op_r;
    logic [ADDR_W-1:0]   rd_r, rs1_r, rs2_r;
    logic [DATA_W-1:0]   a_r, b_r;
    logic [DATA_W-1:0]   alu_result_s;
    logic                alu_carry_s;
    logic                instr_ready_r;
    logic [ADDR_W-1:0]   write_reg_r;
    logic [DATA_W-1:0]   write_data_r;
    logic                reg_write_r;
    logic                done_r;
    logic                zero_r;
    logic                carry_r;
    logic [7:0]          retired_r;

    alu_32bit #(.DATA_W(DATA_W)) u_alu (
        .a      (a_r),
        .b      (b_r),
        .op     (op_r),
        .result (alu_result_s),
        .carry  (alu_carry_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state and accept decode
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (instr_valid) begin
                    state_s  = ST_READ;
                    accept_s = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_READ: state_s = ST_EXEC;
            ST_EXEC: state_s = ST_WB;
            ST_WB:   state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath: instruction latch, operand capture, result/flag registers, retire count
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r          <= OP_NOP;
            rd_r          <= '0;
            rs1_r         <= '0;
            rs2_r         <= '0;
            a_r           <= '0;
            b_r           <= '0;
            instr_ready_r <= 1'b1;
            write_reg_r   <= '0;
            write_data_r  <= '0;
            reg_write_r   <= 1'b0;
            done_r        <= 1'b0;
            zero_r        <= 1'b0;
            carry_r       <= 1'b0;
            retired_r     <= 8'd0;
        end else begin
            instr_ready_r <= (state_s == ST_IDLE);
            // Write enable and done are single-cycle: cleared unless leaving EXEC.
            reg_write_r   <= 1'b0;
            done_r        <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r  <= op_e'(instr[OP_MSB:OP_LSB]);
                        rd_r  <= instr[RD_MSB:RD_LSB];
                        rs1_r <= instr[RS1_MSB:RS1_LSB];
                        rs2_r <= instr[RS2_MSB:RS2_LSB];
                    end
                end
                ST_READ: begin
                    a_r <= ReadData1;
                    b_r <= ReadData2;
                end
                ST_EXEC: begin
                    done_r      <= 1'b1;
                    write_reg_r <= rd_r;
                    if (op_writes_reg(op_r)) begin
                        write_data_r <= alu_result_s;
                        reg_write_r  <= 1'b1;
                        zero_r       <= (alu_result_s == '0);
                    end
                    if (op_sets_carry(op_r)) begin
                        carry_r <= alu_carry_s;
                    end
                end
                ST_WB: begin
                    retired_r <= retired_r + 8'd1;
                end
                default: begin
                    reg_write_r <= 1'b0;
                end
            endcase
        end
    end

    // Read addresses come straight from the latched rs fields, so they are
    // stable through READ and EXEC.
    assign ReadReg1    = rs1_r;
    assign ReadReg2    = rs2_r;
    assign instr_ready = instr_ready_r;
    assign WriteReg    = write_reg_r;
    assign WriteData   = write_data_r;
    assign RegWrite    = reg_write_r;
    assign done        = done_r;
    assign zero_flag   = zero_r;
    assign carry_flag  = carry_r;
    assign retired     = retired_r;

endmodule

// File: tb/tb_exec_wb_unit.sv
// Directed self-checking bench for exec_wb_unit with a 4-entry register file model.
module tb_exec_wb_unit;

    localparam logic [2:0] T_ADD = 3'b000;
    localparam logic [2:0] T_SUB = 3'b001;
    localparam logic [2:0] T_AND = 3'b010;
    localparam logic [2:0] T_OR  = 3'b011;
    localparam logic [2:0] T_XOR = 3'b100;
    localparam logic [2:0] T_SLT = 3'b101;
    localparam logic [2:0] T_SLL = 3'b110;
    localparam logic [2:0] T_NOP = 3'b111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  instr = 9'd0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [1:0]  ReadReg1, ReadReg2, WriteReg;
    logic [31:0] ReadData1, ReadData2, WriteData;
    logic        RegWrite, done, zero_flag, carry_flag;
    logic [7:0]  retired;

    logic [31:0] rf [0:3];
    logic        ld_en = 1'b0;
    logic [1:0]  ld_idx = 2'd0;
    logic [31:0] ld_val = 32'd0;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_ret  = 0;

    // results of run_instr
    int          r_lat, r_rw, r_done, r_rdy;
    logic [31:0] r_wd;
    logic [1:0]  r_wr;

    exec_wb_unit #(.DATA_W(32), .ADDR_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .ReadReg1    (ReadReg1),
        .ReadReg2    (ReadReg2),
        .ReadData1   (ReadData1),
        .ReadData2   (ReadData2),
        .WriteReg    (WriteReg),
        .WriteData   (WriteData),
        .RegWrite    (RegWrite),
        .done        (done),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    assign ReadData1 = rf[ReadReg1];
    assign ReadData2 = rf[ReadReg2];

    // Register file model: DUT write-back, or a bench preload
    always @(posedge clk) begin
        if (RegWrite) rf[WriteReg] <= WriteData;
        else if (ld_en) rf[ld_idx] <= ld_val;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic load_reg(input logic [1:0] idx, input logic [31:0] val);
        ld_en = 1'b1; ld_idx = idx; ld_val = val;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Issue one instruction from IDLE and watch cycles 1..5 after the accept cycle.
    task automatic run_instr(input logic [2:0] op, input logic [1:0] rd,
                             input logic [1:0] rs1, input logic [1:0] rs2);
        r_lat = 0; r_rw = 0; r_done = 0; r_rdy = 0; r_wd = 32'd0; r_wr = 2'd0;
        instr = {op, rd, rs1, rs2};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (RegWrite) begin
                r_rw++;
                if (r_lat == 0) r_lat = c;
                r_wd = WriteData;
                r_wr = WriteReg;
            end
            if (done && r_done == 0) r_done = c;
            if (instr_ready && r_rdy == 0) r_rdy = c;
            if (c < 5) @(negedge clk);
        end
        exp_ret++;
    endtask

    initial begin
        int acc_n, rw_n, dn_n, nop_dn;
        int acc_c [0:3];
        int rw_c  [0:3];
        logic [1:0]  rw_wr [0:3];
        logic [31:0] rw_wd [0:3];

        // ---- reset state
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_writereg", {30'd0, WriteReg}, 32'd0);
        check("rst_writedata", WriteData, 32'd0);
        check("rst_readreg1", {30'd0, ReadReg1}, 32'd0);
        check("rst_readreg2", {30'd0, ReadReg2}, 32'd0);
        check("rst_zero", {31'd0, zero_flag}, 32'd0);
        check("rst_carry", {31'd0, carry_flag}, 32'd0);
        check("rst_retired", {24'd0, retired}, 32'd0);
        check("rst_ready", {31'd0, instr_ready}, 32'd1);

        // ---- ADD: 5 + 7 -> R3
        load_reg(2'd1, 32'd5);
        load_reg(2'd2, 32'd7);
        run_instr(T_ADD, 2'd3, 2'd1, 2'd2);
        check("add_latency", r_lat, 32'd3);
        check("add_rw_cycles", r_rw, 32'd1);
        check("add_writereg", {30'd0, r_wr}, 32'd3);
        check("add_writedata", r_wd, 32'd12);
        check("add_done_cycle", r_done, 32'd3);
        check("add_ready_cycle", r_rdy, 32'd4);
        check("add_rf3", rf[3], 32'd12);
        check("add_zero", {31'd0, zero_flag}, 32'd0);
        check("add_carry", {31'd0, carry_flag}, 32'd0);
        check("add_retired", {24'd0, retired}, exp_ret);

        // ---- SUB: 0 - 1 -> borrow
        load_reg(2'd0, 32'd0);
        load_reg(2'd1, 32'd1);
        run_instr(T_SUB, 2'd2, 2'd0, 2'd1);
        check("sub_writedata", r_wd, 32'hffff_ffff);
        check("sub_carry", {31'd0, carry_flag}, 32'd1);
        check("sub_zero", {31'd0, zero_flag}, 32'd0);
        check("sub_rf2", rf[2], 32'hffff_ffff);

        // ---- SLT signed, then ADD overflow to zero
        load_reg(2'd1, 32'h8000_0000);
        load_reg(2'd2, 32'd1);
        run_instr(T_SLT, 2'd0, 2'd1, 2'd2);
        check("slt_writedata", r_wd, 32'd1);
        check("slt_writereg", {30'd0, r_wr}, 32'd0);
        run_instr(T_ADD, 2'd3, 2'd1, 2'd1);
        check("addovf_writedata", r_wd, 32'd0);
        check("addovf_carry", {31'd0, carry_flag}, 32'd1);
        check("addovf_zero", {31'd0, zero_flag}, 32'd1);

        // ---- logic ops; carry must stay at 1
        load_reg(2'd1, 32'h0000_00f0);
        load_reg(2'd2, 32'h0000_003c);
        run_instr(T_AND, 2'd3, 2'd1, 2'd2);
        check("and_writedata", r_wd, 32'h0000_0030);
        check("and_zero", {31'd0, zero_flag}, 32'd0);
        check("and_carry_kept", {31'd0, carry_flag}, 32'd1);
        run_instr(T_OR, 2'd3, 2'd1, 2'd2);
        check("or_writedata", r_wd, 32'h0000_00fc);
        run_instr(T_XOR, 2'd3, 2'd1, 2'd2);
        check("xor_writedata", r_wd, 32'h0000_00cc);
        load_reg(2'd2, 32'h0000_0024);
        run_instr(T_SLL, 2'd3, 2'd1, 2'd2);
        check("sll_writedata", r_wd, 32'h0000_0f00);

        // ---- SLT false (5 < -1), then NOP keeps zero_flag
        load_reg(2'd1, 32'd5);
        load_reg(2'd2, 32'hffff_ffff);
        run_instr(T_SLT, 2'd3, 2'd1, 2'd2);
        check("slt0_writedata", r_wd, 32'd0);
        check("slt0_zero", {31'd0, zero_flag}, 32'd1);
        run_instr(T_NOP, 2'd3, 2'd1, 2'd2);
        check("nop_rw_cycles", r_rw, 32'd0);
        check("nop_done_cycle", r_done, 32'd3);
        check("nop_zero_kept", {31'd0, zero_flag}, 32'd1);
        check("nop_carry_kept", {31'd0, carry_flag}, 32'd1);
        check("nop_retired", {24'd0, retired}, exp_ret);

        // ---- rd == rs: old value is read
        load_reg(2'd1, 32'd3);
        run_instr(T_ADD, 2'd1, 2'd1, 2'd1);
        check("hazard_writedata", r_wd, 32'd6);
        check("hazard_rf1", rf[1], 32'd6);
        check("hazard_carry", {31'd0, carry_flag}, 32'd0);

        // ---- instr_valid held high across three instructions
        load_reg(2'd1, 32'd10);
        load_reg(2'd2, 32'd4);
        acc_n = 0; rw_n = 0; dn_n = 0;
        for (int c = 0; c <= 12; c++) begin
            if (c == 0) begin instr = {T_ADD, 2'd3, 2'd1, 2'd2}; instr_valid = 1'b1; end
            if (c == 1) instr = {T_SUB, 2'd2, 2'd1, 2'd2};
            if (c == 5) instr = {T_NOP, 6'd0};
            if (c == 9) instr_valid = 1'b0;
            if (instr_valid && instr_ready) begin
                if (acc_n < 4) acc_c[acc_n] = c;
                acc_n++;
            end
            if (RegWrite) begin
                if (rw_n < 4) begin rw_c[rw_n] = c; rw_wr[rw_n] = WriteReg; rw_wd[rw_n] = WriteData; end
                rw_n++;
            end
            if (done) dn_n++;
            @(negedge clk);
        end
        exp_ret += 3;
        check("hold_accepts", acc_n, 32'd3);
        if (acc_n >= 3) begin
            check("hold_acc0", acc_c[0], 32'd0);
            check("hold_acc1", acc_c[1], 32'd4);
            check("hold_acc2", acc_c[2], 32'd8);
        end
        check("hold_rw_count", rw_n, 32'd2);
        if (rw_n >= 2) begin
            check("hold_rw0_cycle", rw_c[0], 32'd3);
            check("hold_rw0_reg", {30'd0, rw_wr[0]}, 32'd3);
            check("hold_rw0_data", rw_wd[0], 32'd14);
            check("hold_rw1_cycle", rw_c[1], 32'd7);
            check("hold_rw1_reg", {30'd0, rw_wr[1]}, 32'd2);
            check("hold_rw1_data", rw_wd[1], 32'd6);
        end
        check("hold_done_count", dn_n, 32'd3);
        check("hold_retired", {24'd0, retired}, exp_ret);

        // ---- reset during EXEC aborts the write
        load_reg(2'd3, 32'h0000_0055);
        instr = {T_ADD, 2'd3, 2'd1, 2'd2};
        instr_valid = 1'b1;
        @(negedge clk);              // READ
        instr_valid = 1'b0;
        @(negedge clk);              // EXEC
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_regwrite", {31'd0, RegWrite}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_ready", {31'd0, instr_ready}, 32'd1);
        check("abort_retired", {24'd0, retired}, 32'd0);
        rw_n = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (RegWrite) rw_n++;
        end
        check("abort_no_write", rw_n, 32'd0);
        check("abort_rf3", rf[3], 32'h0000_0055);

        // ---- 256 NOPs wrap retired
        instr = {T_NOP, 6'd0};
        instr_valid = 1'b1;
        nop_dn = 0;
        for (int c = 0; c < 1200 && nop_dn < 256; c++) begin
            @(negedge clk);
            if (done) begin
                nop_dn++;
                if (nop_dn == 256) instr_valid = 1'b0;
                @(negedge clk);
                if (nop_dn == 255) check("retired_255", {24'd0, retired}, 32'd255);
                if (nop_dn == 256) check("retired_wrap", {24'd0, retired}, 32'd0);
            end
        end
        instr_valid = 1'b0;
        check("nop_total", nop_dn, 32'd256);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
